// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - consumer-side handshake between uart_rx and its reader
interface uart_rx_if;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frame_err;
    logic       overrun;

    modport master (
        input  clr_rdy,
        output rx_data,
        output rdy,
        output frame_err,
        output overrun
    );

    modport slave (
        output clr_rdy,
        input  rx_data,
        input  rdy,
        input  frame_err,
        input  overrun
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, oversampled with a 3-sample majority vote
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      RX,
    input  logic      brg_en,
    uart_rx_if.master bus
);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int MID = OVERSAMPLE / 2;
    localparam logic [TW-1:0] T_PRE  = TW'(MID - 1);
    localparam logic [TW-1:0] T_MID  = TW'(MID);
    localparam logic [TW-1:0] T_POST = TW'(MID + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [1:0]    smp_q, smp_d;
    logic [7:0]    data_q, data_d;
    logic          rdy_q, rdy_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;

    logic rx_s, tick_en, decide, boundary, vote;

    assign rx_s     = sync2_q;
    assign tick_en  = brg_en && (state_q != S_IDLE) && (state_q != S_BREAK);
    assign decide   = tick_en && (tick_q == T_POST);
    assign boundary = tick_en && (tick_q == T_LAST);
    // Third sample is taken live on the decision tick rather than registered.
    assign vote     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            smp_q   <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= RX;
            sync2_q <= sync1_q;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            smp_q   <= smp_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!rx_s) state_d = S_START;
            S_START: begin
                if (decide && vote) state_d = S_IDLE;
                else if (boundary)  state_d = S_DATA;
            end
            S_DATA:  if (boundary && bit_q == 3'd7) state_d = S_STOP;
            // Leave at mid-stop so a back-to-back start edge is still caught.
            S_STOP:  if (decide) state_d = vote ? S_IDLE : S_BREAK;
            S_BREAK: if (rx_s) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        smp_d   = smp_q;
        data_d  = data_q;
        rdy_d   = rdy_q  & ~bus.clr_rdy;
        ferr_d  = ferr_q & ~bus.clr_rdy;
        ovr_d   = ovr_q  & ~bus.clr_rdy;

        if (state_d == S_IDLE || state_d == S_BREAK)
            tick_d = '0;
        else if (tick_en)
            tick_d = (tick_q == T_LAST) ? '0 : tick_q + 1'b1;

        if (tick_en && tick_q == T_PRE) smp_d[0] = rx_s;
        if (tick_en && tick_q == T_MID) smp_d[1] = rx_s;

        if (state_q == S_START && boundary) bit_d = 3'd0;
        if (state_q == S_DATA  && boundary) bit_d = bit_q + 3'd1;
        if (state_q == S_DATA  && decide)   shift_d = {vote, shift_q[7:1]};

        // Set events override a same-cycle clear.
        if (state_q == S_STOP && decide) begin
            if (!vote) begin
                ferr_d = 1'b1;
            end else if (!rdy_q || bus.clr_rdy) begin
                data_d = shift_q;
                rdy_d  = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign bus.rx_data   = data_q;
    assign bus.rdy       = rdy_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at OVERSAMPLE=16, brg_en every 4th clk
module tb_uart_rx;
    localparam int BIT = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic RX = 1'b1;
    logic brg_en = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic [7:0] exp_q[$];

    uart_rx_if bus();

    uart_rx #(.OVERSAMPLE(16)) dut (
        .clk(clk),
        .rst(rst),
        .RX(RX),
        .brg_en(brg_en),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            brg_en = (cyc % 4 == 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic hold(input logic v, input int n);
        RX = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic align();
        @(negedge clk);
        while (cyc % 4 != 0) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] d, input logic stop, input int gbit);
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) begin
            if (i == gbit) begin
                hold(d[i], 32);
                hold(!d[i], 4);
                hold(d[i], 28);
            end else begin
                hold(d[i], BIT);
            end
        end
        hold(stop, BIT);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int gbit);
        align();
        send_bits(d, stop, gbit);
        hold(1'b1, BIT);
    endtask

    task automatic wait_rdy(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if (bus.rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic pulse_clr();
        bus.clr_rdy = 1'b1;
        @(negedge clk);
        bus.clr_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rx_data !== 8'h00 || bus.rdy !== 1'b0 || bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset: got data=%h rdy=%b fe=%b ov=%b expected 00 0 0 0",
                     bus.rx_data, bus.rdy, bus.frame_err, bus.overrun);
        end
    endtask

    task automatic test_basic();
        bit ok;
        logic [7:0] e;
        logic [7:0] d;
        d = 8'hA5;
        exp_q.push_back(d);
        align();
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(d[i], BIT);
        checks++;
        if (bus.rdy !== 1'b0) begin
            failures++;
            $display("FAIL basic_early_rdy: got rdy=%b expected 0 before stop bit", bus.rdy);
        end
        hold(1'b1, BIT);
        hold(1'b1, BIT);
        wait_rdy(ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || bus.rx_data !== e || bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin
            failures++;
            $display("FAIL basic_A5: got rdy=%b data=%h fe=%b ov=%b expected 1 %h 0 0",
                     bus.rdy, bus.rx_data, bus.frame_err, bus.overrun, e);
        end
        pulse_clr();
        checks++;
        if (bus.rdy !== 1'b0) begin
            failures++;
            $display("FAIL basic_clr: got rdy=%b expected 0", bus.rdy);
        end
    endtask

    task automatic test_false_start();
        bit ok;
        logic [7:0] e;
        align();
        hold(1'b0, 16);
        hold(1'b1, 3 * BIT);
        checks++;
        if (bus.rdy !== 1'b0 || bus.frame_err !== 1'b0) begin
            failures++;
            $display("FAIL false_start: got rdy=%b fe=%b expected 0 0", bus.rdy, bus.frame_err);
        end
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, -1);
        wait_rdy(ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || bus.rx_data !== e) begin
            failures++;
            $display("FAIL after_false_start: got rdy=%b data=%h expected 1 %h", bus.rdy, bus.rx_data, e);
        end
        pulse_clr();
    endtask

    task automatic test_majority();
        bit ok;
        logic [7:0] e;
        logic [7:0] pat[2];
        pat[0] = 8'h00;
        pat[1] = 8'hFF;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(pat[k]);
            send_frame(pat[k], 1'b1, 3);
            wait_rdy(ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || bus.rx_data !== e || bus.frame_err !== 1'b0) begin
                failures++;
                $display("FAIL majority_%0d: got rdy=%b data=%h fe=%b expected 1 %h 0",
                         k, bus.rdy, bus.rx_data, bus.frame_err, e);
            end
            pulse_clr();
        end
    endtask

    task automatic test_break();
        bit ok;
        logic [7:0] e;
        align();
        send_bits(8'h5A, 1'b0, -1);
        hold(1'b0, 3 * BIT);
        hold(1'b1, 2 * BIT);
        checks++;
        if (bus.frame_err !== 1'b1 || bus.rdy !== 1'b0 || bus.rx_data !== 8'hFF || bus.overrun !== 1'b0) begin
            failures++;
            $display("FAIL framing: got fe=%b rdy=%b data=%h ov=%b expected 1 0 ff 0",
                     bus.frame_err, bus.rdy, bus.rx_data, bus.overrun);
        end
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, -1);
        wait_rdy(ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || bus.rx_data !== e || bus.frame_err !== 1'b1) begin
            failures++;
            $display("FAIL after_break: got rdy=%b data=%h fe=%b expected 1 %h 1",
                     bus.rdy, bus.rx_data, bus.frame_err, e);
        end
        pulse_clr();
        checks++;
        if (bus.frame_err !== 1'b0 || bus.rdy !== 1'b0) begin
            failures++;
            $display("FAIL break_clr: got fe=%b rdy=%b expected 0 0", bus.frame_err, bus.rdy);
        end
    endtask

    task automatic test_back_to_back(output int d);
        int c0;
        int c1;
        logic [7:0] e;
        c0 = -1;
        c1 = -1;
        exp_q.push_back(8'h11);
        align();
        fork
            begin
                send_bits(8'h11, 1'b1, -1);
                c0 = cyc;
                send_bits(8'h22, 1'b1, -1);
                hold(1'b1, BIT);
            end
            begin
                for (int n = 0; n < 3000 && c1 < 0; n++) begin
                    @(negedge clk);
                    if (bus.overrun === 1'b1) c1 = cyc;
                end
            end
        join
        d = (c1 >= 0 && c0 >= 0) ? c1 - c0 : 0;
        e = exp_q.pop_front();
        checks++;
        if (c1 < 0 || bus.overrun !== 1'b1 || bus.rdy !== 1'b1 || bus.rx_data !== e) begin
            failures++;
            $display("FAIL overrun: got ov=%b rdy=%b data=%h expected 1 1 %h",
                     bus.overrun, bus.rdy, bus.rx_data, e);
        end
        pulse_clr();
        checks++;
        if (bus.overrun !== 1'b0 || bus.rdy !== 1'b0) begin
            failures++;
            $display("FAIL overrun_clr: got ov=%b rdy=%b expected 0 0", bus.overrun, bus.rdy);
        end
    endtask

    task automatic test_priority(input int d);
        int c0;
        logic [7:0] e;
        c0 = -1;
        exp_q.push_back(8'h22);
        align();
        fork
            begin
                send_bits(8'h11, 1'b1, -1);
                c0 = cyc;
                send_bits(8'h22, 1'b1, -1);
                hold(1'b1, BIT);
            end
            begin
                while (c0 < 0) @(negedge clk);
                if (d > 1) begin
                    while (cyc < c0 + d - 1) @(negedge clk);
                    bus.clr_rdy = 1'b1;
                    @(negedge clk);
                    bus.clr_rdy = 1'b0;
                end
            end
        join
        e = exp_q.pop_front();
        checks++;
        if (bus.rdy !== 1'b1 || bus.rx_data !== e || bus.overrun !== 1'b0 || bus.frame_err !== 1'b0) begin
            failures++;
            $display("FAIL priority: got rdy=%b data=%h ov=%b fe=%b expected 1 %h 0 0",
                     bus.rdy, bus.rx_data, bus.overrun, bus.frame_err, e);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [7:0] e;
        logic [7:0] d;
        d = 8'hC3;
        align();
        hold(1'b0, BIT);
        for (int i = 0; i < 4; i++) hold(d[i], BIT);
        hold(d[4], 32);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        RX = 1'b1;
        checks++;
        if (bus.rx_data !== 8'h00 || bus.rdy !== 1'b0 || bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: got data=%h rdy=%b fe=%b ov=%b expected 00 0 0 0",
                     bus.rx_data, bus.rdy, bus.frame_err, bus.overrun);
        end
        hold(1'b1, 2 * BIT);
        checks++;
        if (bus.rdy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_quiet: got rdy=%b expected 0", bus.rdy);
        end
        exp_q.push_back(8'h96);
        send_frame(8'h96, 1'b1, -1);
        wait_rdy(ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || bus.rx_data !== e || bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin
            failures++;
            $display("FAIL after_reset: got rdy=%b data=%h fe=%b ov=%b expected 1 %h 0 0",
                     bus.rdy, bus.rx_data, bus.frame_err, bus.overrun, e);
        end
    endtask

    initial begin
        int d;
        bus.clr_rdy = 1'b0;
        test_reset();
        test_basic();
        test_false_start();
        test_majority();
        test_break();
        test_back_to_back(d);
        test_priority(d);
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
